// File: rtl/ula_nibble_seq_if.sv
// ula_nibble_seq_if: bundles the host request/status signals and the
// external 4-bit ALU signals of the nibble-serial sequencer.
//   host side : start, op_s, op_m, cin, opa, opb -> busy, done, result, cout, eq
//   ALU side  : alu_a, alu_b, alu_s, alu_m, alu_cin -> alu_f, alu_cout, alu_eq
//   slave     : the sequencer; master: host plus ALU (environment).
interface ula_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [3:0]   op_s;
  logic         op_m;
  logic         cin;
  logic [W-1:0] opa;
  logic [W-1:0] opb;

  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         eq;

  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout;
  logic         alu_eq;

  modport slave (
    input  start, op_s, op_m, cin, opa, opb, alu_f, alu_cout, alu_eq,
    output busy, done, result, cout, eq, alu_a, alu_b, alu_s, alu_m, alu_cin
  );

  modport master (
    output start, op_s, op_m, cin, opa, opb, alu_f, alu_cout, alu_eq,
    input  busy, done, result, cout, eq, alu_a, alu_b, alu_s, alu_m, alu_cin
  );
endinterface

// File: rtl/ula_nibble_seq.sv
// ula_nibble_seq: runs a W-bit operation through an external 4-bit ALU,
// one nibble per cycle, LSB nibble first, chaining the carry between nibbles.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ula_nibble_seq_if.slave (host request/status + ALU drive/response)
module ula_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ula_nibble_seq_if.slave   bus
);
  localparam int unsigned W        = 4 * NIBBLES;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     opa_q, opb_q, result_q;
  logic [3:0]       op_s_q;
  logic             op_m_q, cin_q;
  logic             busy_q, done_q, cout_q, eq_q;
  logic             accept_c, last_c;

  // Next-state decode
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath. Operands shift right one nibble per RUN edge so the low nibble
  // always feeds the ALU; after the last shift they are zero, which also
  // leaves alu_a/alu_b at 0 in IDLE. cin_q doubles as the inter-nibble carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_s_q   <= '0;
      op_m_q   <= 1'b0;
      cin_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        opa_q    <= bus.opa;
        opb_q    <= bus.opb;
        op_s_q   <= bus.op_s;
        op_m_q   <= bus.op_m;
        cin_q    <= bus.cin;
        idx_q    <= '0;
        result_q <= '0;
        cout_q   <= 1'b0;
        eq_q     <= 1'b1;
        busy_q   <= 1'b1;
      end else if (state_q == RUN) begin
        opa_q <= opa_q >> 4;
        opb_q <= opb_q >> 4;
        cin_q <= bus.alu_cout;
        eq_q  <= eq_q & bus.alu_eq;
        idx_q <= idx_q + IDX_W'(1);
        for (int n = 0; n < int'(NIBBLES); n++) begin
          if (idx_q == IDX_W'(n)) result_q[4*n +: 4] <= bus.alu_f;
        end
        if (last_c) begin
          idx_q  <= '0;
          op_s_q <= '0;
          op_m_q <= 1'b0;
          cin_q  <= 1'b0;
          cout_q <= bus.alu_cout;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.alu_a   = opa_q[3:0];
  assign bus.alu_b   = opb_q[3:0];
  assign bus.alu_s   = op_s_q;
  assign bus.alu_m   = op_m_q;
  assign bus.alu_cin = cin_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.eq      = eq_q;
endmodule

// File: tb/tb_ula_nibble_seq.sv
// tb_ula_nibble_seq: directed bench for ula_nibble_seq (NIBBLES=4) with a
// behavioural 4-bit ALU: arithmetic op_s=0001 is A+B+cin with eq=(A==B),
// logic op_s=0110 is A^B; everything else returns zeros.
module tb_ula_nibble_seq;
  localparam int unsigned NIB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  ula_nibble_seq_if #(.NIBBLES(NIB)) bus ();

  ula_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural external ALU
  always_comb begin : alu_model
    logic [4:0] sum;
    sum          = 5'(bus.alu_a) + 5'(bus.alu_b) + 5'(bus.alu_cin);
    bus.alu_f    = 4'h0;
    bus.alu_cout = 1'b0;
    bus.alu_eq   = 1'b0;
    if (!bus.alu_m && bus.alu_s == 4'b0001) begin
      bus.alu_f    = sum[3:0];
      bus.alu_cout = sum[4];
      bus.alu_eq   = (bus.alu_a == bus.alu_b);
    end else if (bus.alu_m && bus.alu_s == 4'b0110) begin
      bus.alu_f = bus.alu_a ^ bus.alu_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_outs();
    return 32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_cin});
  endfunction

  // Issues one operation and returns at the sample where done is high.
  // hold=1 keeps start asserted and scrambles operands/opcode during RUN.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic c, input logic hold,
                       input logic [15:0] exp_res, input logic exp_cout, input logic exp_eq,
                       input logic [3:0] exp_cins);
    int         busy_cnt;
    int         done_at;
    logic [3:0] cins;
    bus.opa   = a;
    bus.opb   = b;
    bus.op_s  = s;
    bus.op_m  = m;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      bus.opa  = ~a;
      bus.opb  = ~b;
      bus.op_s = ~s;
      bus.op_m = ~m;
      bus.cin  = ~c;
    end else begin
      bus.start = 1'b0;
    end
    chk({tag, "_clear_at_accept"}, {15'd0, bus.result, bus.cout}, 32'd0);
    chk({tag, "_eq_set_at_accept"}, 32'(bus.eq), 32'd1);
    busy_cnt = 0;
    done_at  = -1;
    cins     = 4'h0;
    for (int k = 1; k <= int'(NIB) + 3; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (bus.busy) begin
        if (busy_cnt < 4) cins[busy_cnt] = bus.alu_cin;
        busy_cnt++;
      end
    end
    chk({tag, "_done_latency"}, 32'(done_at), 32'(NIB + 1));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(NIB));
    chk({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    chk({tag, "_eq"}, 32'(bus.eq), 32'(exp_eq));
    chk({tag, "_alu_cin_seq"}, 32'(cins), 32'(exp_cins));
  endtask

  // One cycle in IDLE: done drops, ALU drive is zero, results hold.
  task automatic idle_check(input string tag, input logic [15:0] exp_res, input logic exp_cout,
                            input logic exp_eq);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_alu_zero"}, alu_outs(), 32'd0);
    chk({tag, "_hold"}, {14'd0, bus.result, bus.cout, bus.eq}, {14'd0, exp_res, exp_cout, exp_eq});
  endtask

  initial begin
    int done_seen;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.op_s  = '0;
    bus.op_m  = 1'b0;
    bus.cin   = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_status", {15'd0, bus.busy, bus.done, bus.result}, 32'd0);
    chk("reset_cout_eq", {30'd0, bus.cout, bus.eq}, 32'd0);
    chk("reset_alu", alu_outs(), 32'd0);

    // Start accepted at the first edge after release; start held, operands
    // scrambled, then a back-to-back carry-ripple op in the done cycle.
    rst_n = 1'b1;
    do_op("add", 16'h1234, 16'h0FFF, 4'b0001, 1'b0, 1'b0, 1'b1,
          16'h2233, 1'b0, 1'b0, 4'b1110);
    do_op("ripple", 16'hFFFF, 16'h0001, 4'b0001, 1'b0, 1'b0, 1'b0,
          16'h0000, 1'b1, 1'b0, 4'b1110);
    idle_check("ripple", 16'h0000, 1'b1, 1'b0);

    do_op("xor", 16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 1'b0,
          16'hAA55, 1'b0, 1'b0, 4'b0000);
    idle_check("xor", 16'hAA55, 1'b0, 1'b0);

    do_op("equal", 16'h5A5A, 16'h5A5A, 4'b0001, 1'b0, 1'b0, 1'b0,
          16'hB4B4, 1'b0, 1'b1, 4'b1010);
    idle_check("equal", 16'hB4B4, 1'b0, 1'b1);

    // Reset while idx=2
    bus.opa   = 16'h1234;
    bus.opb   = 16'h0FFF;
    bus.op_s  = 4'b0001;
    bus.op_m  = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {15'd0, bus.busy, bus.done, bus.result}, 32'd0);
    chk("mid_rst_cout_eq", {30'd0, bus.cout, bus.eq}, 32'd0);
    chk("mid_rst_alu", alu_outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen++;
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);

    do_op("post_rst", 16'h1111, 16'h2222, 4'b0001, 1'b0, 1'b1, 1'b0,
          16'h3334, 1'b0, 1'b0, 4'b0001);
    idle_check("post_rst", 16'h3334, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
